zbt_pixel_fetch: RTL and testbench

Display-side reader for the video frame buffer in ZBT RAM. Each 36-bit word holds two RGB666 pixels, written by the NTSC capture stage at address {field_row[8:0], field, x[9:1]}. The block sits between the XGA timing generator and the video DAC. It issues one read address per display pixel, absorbs the ZBT read pipeline latency, de-interlaces by mapping display line to (field, field_row), and selects the pixel half. It outputs 24-bit RGB with hsync/vsync/blank delayed to match.

---
 rtl/zbt_pixel_fetch.sv | 106 ++++++++++
 tb/tb_zbt_pixel_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_pixel_fetch.sv
// zbt_pixel_fetch
//
// Display-side reader for the ZBT video frame buffer. Every pixel clock it
// issues a read address derived from the display position, waits out the ZBT
// read pipeline, de-interlaces the two captured fields, and selects the
// correct 18-bit half of the returned 36-bit word. Sync and blank inputs are
// delayed to stay aligned with the pixel data.
//
// Ports:
//   clk             display pixel clock, all logic on its rising edge
//   rst             asynchronous active-high reset
//   hcount, vcount  display column / line from the timing generator
//   hsync, vsync    active-low syncs, blank active-high
//   vram_read_data  ZBT read data, valid 2 cycles after its address
//   vram_addr       registered ZBT read address {field_row, field, x[9:1]}
//   vram_pixel      selected RGB666 pixel (black outside window / in blank)
//   vr_pixel        RGB888 expansion of vram_pixel, same register stage
//   hsync_out, vsync_out, blank_out  inputs delayed 4 cycles
//
// Total latency from inputs to pixel/sync outputs is 4 cycles.

module zbt_pixel_fetch #(
    parameter logic [10:0] X_LIMIT = 11'd1024,
    parameter logic [9:0]  Y_LIMIT = 10'd768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [35:0] vram_read_data,
    output logic [18:0] vram_addr,
    output logic [17:0] vram_pixel,
    output logic [23:0] vr_pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    // 6-bit colour channel to 8 bits by replicating the top two bits.
    function automatic logic [7:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

    logic        in_win_s;
    logic [17:0] pix_next_s;
    logic [2:0]  sel_dly_r;
    logic [2:0]  win_dly_r;
    logic [3:0]  hsync_dly_r;
    logic [3:0]  vsync_dly_r;
    logic [3:0]  blank_dly_r;

    // Current position lies inside the displayed image window.
    always_comb begin
        in_win_s = (hcount < X_LIMIT) && (vcount < Y_LIMIT);
    end

    // Next output pixel: select and window flag are 3 cycles old so they line
    // up with the data returning for the same position. Stage [2] of the blank
    // line is used here so that it becomes visible together with blank_out.
    always_comb begin
        pix_next_s = 18'd0;
        if (!win_dly_r[2] || blank_dly_r[2]) begin
            pix_next_s = 18'd0;
        end else if (sel_dly_r[2]) begin
            pix_next_s = vram_read_data[17:0];
        end else begin
            pix_next_s = vram_read_data[35:18];
        end
    end

    // Address register, delay lines and output pixel register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_addr   <= 19'd0;
            vram_pixel  <= 18'd0;
            vr_pixel    <= 24'd0;
            sel_dly_r   <= 3'b000;
            win_dly_r   <= 3'b000;
            hsync_dly_r <= 4'b1111;
            vsync_dly_r <= 4'b1111;
            blank_dly_r <= 4'b1111;
        end else begin
            // Even lines read field 0, odd lines field 1, both at row vcount/2.
            // hcount[10] is deliberately dropped: columns past 1023 alias but
            // are blacked out by the window flag.
            vram_addr   <= {vcount[9:1], vcount[0], hcount[9:1]};
            sel_dly_r   <= {sel_dly_r[1:0], hcount[0]};
            win_dly_r   <= {win_dly_r[1:0], in_win_s};
            hsync_dly_r <= {hsync_dly_r[2:0], hsync};
            vsync_dly_r <= {vsync_dly_r[2:0], vsync};
            blank_dly_r <= {blank_dly_r[2:0], blank};
            vram_pixel  <= pix_next_s;
            vr_pixel    <= {expand6(pix_next_s[17:12]),
                            expand6(pix_next_s[11:6]),
                            expand6(pix_next_s[5:0])};
        end
    end

    assign hsync_out = hsync_dly_r[3];
    assign vsync_out = vsync_dly_r[3];
    assign blank_out = blank_dly_r[3];

endmodule

// File: tb/tb_zbt_pixel_fetch.sv
// Self-checking bench for zbt_pixel_fetch. A behavioural ZBT model returns a
// deterministic word per address two cycles after the address is issued, and
// a queue-based reference model predicts every output 4 cycles after input.

module tb_zbt_pixel_fetch;

    localparam int XL = 640;
    localparam int YL = 768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank = 1'b1;
    logic [35:0] vram_read_data;
    logic [18:0] vram_addr;
    logic [17:0] vram_pixel;
    logic [23:0] vr_pixel;
    logic        hsync_out, vsync_out, blank_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [17:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_vec, obs_vec;
    logic [10:0] h_r = 11'd0;
    logic [9:0]  v_r = 10'd0;
    logic [18:0] addr_d1 = 19'd0, addr_d2 = 19'd0;

    zbt_pixel_fetch #(.X_LIMIT(11'(XL)), .Y_LIMIT(10'(YL))) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .vram_read_data(vram_read_data), .vram_addr(vram_addr),
        .vram_pixel(vram_pixel), .vr_pixel(vr_pixel),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    // Word address: field row and field together equal vcount, word column is x/2.
    function automatic logic [18:0] addr_of(input logic [10:0] h, input logic [9:0] v);
        int a;
        a = int'(v) * 512 + (int'(h) % 1024) / 2;
        return 19'(a);
    endfunction

    // RAM contents: two fixed test words, otherwise an address-derived pattern
    // with both halves guaranteed nonzero.
    function automatic logic [35:0] zbt_word(input logic [18:0] a);
        if (a == {9'd160, 1'b1, 9'd30}) return {18'h3F000, 18'h00FFF};
        if (a == {9'd5, 1'b0, 9'd50})   return {18'h20820, 18'h20820};
        return {2'b10, a[15:0], 2'b01, a[18:3]};
    endfunction

    function automatic logic [23:0] expand_pix(input logic [17:0] p);
        int r, g, b;
        r = int'(p[17:12]); g = int'(p[11:6]); b = int'(p[5:0]);
        return {8'(r * 4 + r / 16), 8'(g * 4 + g / 16), 8'(b * 4 + b / 16)};
    endfunction

    function automatic logic [17:0] model_pix(input logic [10:0] h, input logic [9:0] v, input logic bl);
        logic [35:0] w;
        if (int'(h) >= XL || int'(v) >= YL || bl) return 18'd0;
        w = zbt_word(addr_of(h, v));
        if (int'(h) % 2 == 1) return w[17:0];
        return w[35:18];
    endfunction

    // ZBT read pipeline: data for an address is valid 2 cycles after it appears.
    always @(posedge clk) begin
        addr_d1 <= vram_addr;
        addr_d2 <= addr_d1;
    end
    assign vram_read_data = zbt_word(addr_d2);

    task automatic model_reset();
        exp_t blk;
        blk = '{pix: 18'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};
        exp_q.delete();
        repeat (3) exp_q.push_back(blk);
    endtask

    // Apply one set of inputs for one clock, sample outputs and prediction.
    task automatic cycle(input logic [10:0] h, input logic [9:0] v,
                         input logic hs, input logic vs, input logic bl);
        exp_t e, cur;
        hcount = h; vcount = v; hsync = hs; vsync = vs; blank = bl;
        @(posedge clk);
        #1;
        e = '{pix: model_pix(h, v, bl), hs: hs, vs: vs, bl: bl};
        exp_q.push_back(e);
        cur = exp_q.pop_front();
        exp_vec = {addr_of(h, v), cur.pix, expand_pix(cur.pix), cur.hs, cur.vs, cur.bl};
        obs_vec = {vram_addr, vram_pixel, vr_pixel, hsync_out, vsync_out, blank_out};
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        logic hs, vs, bl;
        h_r = (h_r == 11'd1343) ? 11'd0 : h_r + 11'd1;
        if (h_r == 11'd0) v_r = (v_r == 10'd805) ? 10'd0 : v_r + 10'd1;
        hs = ($urandom_range(7, 0) != 0);
        vs = ($urandom_range(15, 0) != 0);
        bl = ($urandom_range(5, 0) == 0);
        cycle(h_r, v_r, hs, vs, bl);
    endtask

    task automatic test_reset();
        h_r = 11'd100; v_r = 10'd40;
        repeat (10) begin
            rand_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_pre got=%h exp=%h", obs_vec, exp_vec); end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vram_addr, vram_pixel, vr_pixel, hsync_out, vsync_out, blank_out} !== {19'd0, 18'd0, 24'd0, 3'b111}) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", {vram_addr, vram_pixel, vr_pixel, hsync_out, vsync_out, blank_out}, {19'd0, 18'd0, 24'd0, 3'b111});
        end
        @(negedge clk); @(negedge clk);
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(11'(200 + i), 10'd40, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_post cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i < 3) begin
                checks++;
                if ({vram_pixel, hsync_out, blank_out} !== {18'd0, 2'b11}) begin
                    failures++;
                    $display("FAIL reset_black cyc=%0d got=%h exp=%h", i, {vram_pixel, hsync_out, blank_out}, {18'd0, 2'b11});
                end
            end
        end
    endtask

    task automatic test_addr_map_select();
        for (int i = 0; i < 5; i++) begin
            cycle(11'(60 + i), 10'd321, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL select cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i == 1) begin
                checks++;
                if (vram_addr !== {9'd160, 1'b1, 9'd30}) begin failures++; $display("FAIL addr_map got=%h exp=%h", vram_addr, {9'd160, 1'b1, 9'd30}); end
            end
            if (i == 3) begin
                checks++;
                if ({vram_pixel, vr_pixel} !== {18'h3F000, 24'hFF0000}) begin failures++; $display("FAIL select_even got=%h exp=%h", {vram_pixel, vr_pixel}, {18'h3F000, 24'hFF0000}); end
            end
            if (i == 4) begin
                checks++;
                if ({vram_pixel, vr_pixel} !== {18'h00FFF, 24'h00FFFF}) begin failures++; $display("FAIL select_odd got=%h exp=%h", {vram_pixel, vr_pixel}, {18'h00FFF, 24'h00FFFF}); end
            end
        end
    endtask

    task automatic test_expansion();
        for (int i = 0; i < 4; i++) begin
            cycle(11'(100 + i), 10'd10, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL expand cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
        end
        checks++;
        if ({vram_pixel, vr_pixel} !== {18'h20820, 24'h828282}) begin failures++; $display("FAIL expand_grey got=%h exp=%h", {vram_pixel, vr_pixel}, {18'h20820, 24'h828282}); end
    endtask

    task automatic test_window();
        for (int i = 0; i < 5; i++) begin
            cycle(11'(639 + i), 10'd321, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL window_x cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i == 3) begin
                checks++;
                if (vram_pixel === 18'd0) begin failures++; $display("FAIL window_x639 got=%h exp=nonzero", vram_pixel); end
            end
            if (i == 4) begin
                checks++;
                if (vram_pixel !== 18'd0) begin failures++; $display("FAIL window_x640 got=%h exp=%h", vram_pixel, 18'd0); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle((i == 0) ? 11'd100 : 11'(99 + i), (i == 0) ? 10'd768 : 10'd767, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL window_y cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i == 1) begin
                checks++;
                if (vram_addr !== {9'd383, 1'b1, 9'd50}) begin failures++; $display("FAIL addr_767 got=%h exp=%h", vram_addr, {9'd383, 1'b1, 9'd50}); end
            end
            if (i == 3) begin
                checks++;
                if (vram_pixel !== 18'd0) begin failures++; $display("FAIL window_y768 got=%h exp=%h", vram_pixel, 18'd0); end
            end
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 6; i++) begin
            cycle(11'(200 + i), 10'd50, (i != 1), 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL hsync_pulse cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i >= 3) begin
                checks++;
                if (hsync_out !== (i != 4)) begin failures++; $display("FAIL hsync_align cyc=%0d got=%b exp=%b", i, hsync_out, (i != 4)); end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(11'(300 + i), 10'd51, 1'b1, 1'b1, (i == 1));
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL blank_pulse cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            if (i == 4) begin
                checks++;
                if ({vram_pixel, blank_out} !== {18'd0, 1'b1}) begin failures++; $display("FAIL blank_align got=%h exp=%h", {vram_pixel, blank_out}, {18'd0, 1'b1}); end
            end
            if (i == 3 || i == 5) begin
                checks++;
                if (vram_pixel === 18'd0 || blank_out !== 1'b0) begin failures++; $display("FAIL blank_neighbour cyc=%0d pix=%h blank=%b", i, vram_pixel, blank_out); end
            end
        end
    endtask

    task automatic test_back_to_back();
        h_r = 11'd1300; v_r = 10'd765;
        for (int i = 0; i < 1500; i++) begin
            rand_cycle();
            checks++;
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL random cyc=%0d h=%0d v=%0d got=%h exp=%h", i, h_r, v_r, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        test_reset();
        test_addr_map_select();
        test_expansion();
        test_window();
        test_sync();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
